regfile_dump: RTL and testbench

Sequential reader for the register file: on a start pulse, walks an inclusive register range and streams each register value out on a valid/ready interface. It borrows the register file's two combinational read ports (rs1/rs2 -> x1/x2) from the core through a req/gnt handshake and reads two registers per grant cycle. It sits beside the core on the debug/trace path and feeds a UART or trace sink.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_dump_buf.sv | 45 ++++
 rtl/regfile_dump.sv | 119 +++++++++++
 tb/tb_regfile_dump.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types for the register-file dump path.
//   XLEN / NREG / REG_AW : data width, register count, index width
//   reg_idx_t, word_t    : register index and register value
//   dump_entry_t         : one streamed word tagged with its register index
//   dump_state_t         : dump controller states
package regfile_pkg;
  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   word_t;

  typedef struct packed {
    word_t    data;
    reg_idx_t idx;
  } dump_entry_t;

  typedef enum logic [1:0] {IDLE, RUN, FIN} dump_state_t;
endpackage

// File: rtl/regfile_dump_buf.sv
// Two-entry output buffer for the dump stream.
//   clk, reset  : clock and synchronous active-high reset
//   push        : load a captured pair (push0 always, push1 if push1_valid)
//   pop         : head entry leaves the buffer this cycle
//   can_push    : buffer is empty, or its only word is being popped now
//   count, head : occupancy and head entry
// A push replaces the whole contents, so callers may only push when
// can_push is high; that is what makes pop+push on the last word legal.
module regfile_dump_buf
  import regfile_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  dump_entry_t push0,
  input  logic        push1_valid,
  input  dump_entry_t push1,
  input  logic        pop,
  output logic        can_push,
  output logic [1:0]  count,
  output dump_entry_t head
);
  dump_entry_t head_reg;
  dump_entry_t tail_reg;
  logic [1:0]  count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= 2'd0;
    end else if (push) begin
      head_reg  <= push0;
      tail_reg  <= push1;
      count_reg <= push1_valid ? 2'd2 : 2'd1;
    end else if (pop && count_reg != 2'd0) begin
      head_reg  <= tail_reg;
      count_reg <= count_reg - 2'd1;
    end
  end

  assign can_push = (count_reg == 2'd0) || (count_reg == 2'd1 && pop);
  assign count    = count_reg;
  assign head     = head_reg;
endmodule

// File: rtl/regfile_dump.sv
// Sequential register-file reader. On start it walks first_reg..last_reg,
// borrowing the core's two regfile read ports through port_req/port_gnt and
// capturing two registers per granted cycle, then streams them out on a
// valid/ready interface with the register index and a last marker.
//   clk, reset                     : clock, synchronous active-high reset
//   start, first_reg, last_reg     : dump request and inclusive range
//   busy, done                     : dump running / one-cycle completion pulse
//   port_req, port_gnt             : read-port ownership handshake
//   rs1, rs2, x1, x2               : borrowed regfile read ports
//   out_valid/ready/data/index/last: output word stream
module regfile_dump
  import regfile_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     start,
  input  reg_idx_t first_reg,
  input  reg_idx_t last_reg,
  output logic     busy,
  output logic     done,
  output logic     port_req,
  input  logic     port_gnt,
  output reg_idx_t rs1,
  output reg_idx_t rs2,
  input  word_t    x1,
  input  word_t    x2,
  output logic     out_valid,
  input  logic     out_ready,
  output word_t    out_data,
  output reg_idx_t out_index,
  output logic     out_last
);
  dump_state_t state_reg, state_next;

  // One bit wider than an index so that a range ending at the top register
  // terminates instead of wrapping back to zero.
  logic [REG_AW:0] idx_reg;
  logic [REG_AW:0] idx_plus1;
  logic [REG_AW:0] idx_plus2;
  logic [REG_AW:0] last_ext;
  reg_idx_t        last_idx_reg;
  reg_idx_t        rs1_reg;
  reg_idx_t        rs2_reg;

  logic        capture;
  logic        pop;
  logic        can_push;
  logic [1:0]  buf_count;
  dump_entry_t buf_head;
  dump_entry_t entry0;
  dump_entry_t entry1;

  assign idx_plus1 = idx_reg + 1'b1;
  assign idx_plus2 = idx_reg + 2'd2;
  assign last_ext  = {1'b0, last_idx_reg};

  assign entry0  = '{data: x1, idx: idx_reg[REG_AW-1:0]};
  assign entry1  = '{data: x2, idx: idx_plus1[REG_AW-1:0]};
  assign pop     = out_valid && out_ready;
  assign capture = (state_reg == RUN) && port_gnt && (idx_reg <= last_ext) && can_push;

  regfile_dump_buf u_buf (
    .clk         (clk),
    .reset       (reset),
    .push        (capture),
    .push0       (entry0),
    .push1_valid (idx_plus1 <= last_ext),
    .push1       (entry1),
    .pop         (pop),
    .can_push    (can_push),
    .count       (buf_count),
    .head        (buf_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      last_idx_reg <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        idx_reg      <= {1'b0, first_reg};
        last_idx_reg <= last_reg;
        rs1_reg      <= first_reg;
        rs2_reg      <= first_reg + 1'b1;
      end else if (capture) begin
        // Read addresses move with the counter, so they stay put while the
        // grant is withheld.
        idx_reg <= idx_plus2;
        rs1_reg <= idx_plus2[REG_AW-1:0];
        rs2_reg <= idx_plus2[REG_AW-1:0] + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (first_reg > last_reg) ? FIN : RUN;
      RUN:     if (pop && out_last) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state_reg == RUN);
  assign port_req  = (state_reg == RUN);
  assign done      = (state_reg == FIN);
  assign rs1       = rs1_reg;
  assign rs2       = rs2_reg;
  assign out_valid = (buf_count != 2'd0);
  assign out_data  = buf_head.data;
  assign out_index = buf_head.idx;
  // Gated by valid so the reset contents (index 0 == last 0) do not flag.
  assign out_last  = out_valid && (buf_head.idx == last_idx_reg);
endmodule

// File: tb/tb_regfile_dump.sv
// Randomized bench for regfile_dump. A behavioural regfile array answers the
// read ports; each dump's expected word list is built directly from the
// requested range and compared against the observed transfers.
module tb_regfile_dump;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  first_reg = '0;
  logic [4:0]  last_reg = '0;
  logic        busy, done, port_req, out_valid, out_last;
  logic        port_gnt = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  rs1, rs2, out_index;
  logic [31:0] x1, x2, out_data;

  logic [31:0] regs [32];
  assign x1 = regs[rs1];
  assign x2 = regs[rs2];

  always #5 clk = ~clk;

  regfile_dump dut (
    .clk(clk), .reset(reset), .start(start), .first_reg(first_reg),
    .last_reg(last_reg), .busy(busy), .done(done), .port_req(port_req),
    .port_gnt(port_gnt), .rs1(rs1), .rs2(rs2), .x1(x1), .x2(x2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  int          n_exp, n_xfer, n_done, cur_last, start_cyc;
  int          first_req_cyc, first_valid_cyc, first_xfer_cyc, last_xfer_cyc;
  bit          saw_req, saw_valid;
  bit          prev_stall, prev_hold_rs;
  logic [31:0] prev_data;
  logic [4:0]  prev_index, prev_rs1, prev_rs2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Stream monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_index", out_index, prev_index);
      end
      if (prev_hold_rs && port_req) begin
        check("hold_rs1", rs1, prev_rs1);
        check("hold_rs2", rs2, prev_rs2);
      end
      if (port_req) begin
        saw_req = 1;
        if (first_req_cyc < 0) first_req_cyc = cyc;
      end
      if (out_valid) begin
        saw_valid = 1;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", n_xfer + 1, n_exp);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word_index", out_index, e.idx);
          check("word_data", out_data, e.data);
          check("word_last", out_last, (e.idx == cur_last) ? 1 : 0);
        end
        n_xfer++;
        if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
      end
      if (done) begin
        n_done++;
        check("done_cyc", cyc, (n_exp == 0) ? start_cyc + 1 : last_xfer_cyc + 1);
        check("done_busy", busy, 0);
        check("done_req", port_req, 0);
      end
      prev_stall   = out_valid && !out_ready;
      prev_data    = out_data;
      prev_index   = out_index;
      prev_hold_rs = port_req && !port_gnt;
      prev_rs1     = rs1;
      prev_rs2     = rs2;
    end
  end

  task automatic check_zero(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_req"}, port_req, 0);
    check({pfx, "_rs1"}, rs1, 0);
    check({pfx, "_rs2"}, rs2, 0);
    check({pfx, "_valid"}, out_valid, 0);
    check({pfx, "_data"}, out_data, 0);
    check({pfx, "_index"}, out_index, 0);
    check({pfx, "_last"}, out_last, 0);
  endtask

  // Build the expected word list for an inclusive range and pulse start.
  task automatic begin_dump(input int f, input int l);
    exp_q.delete();
    n_exp = 0;
    for (int i = f; i <= l; i++) begin
      exp_q.push_back('{i, regs[i]});
      n_exp++;
    end
    n_xfer = 0; n_done = 0; saw_req = 0; saw_valid = 0;
    first_req_cyc = -1; first_valid_cyc = -1;
    first_xfer_cyc = -1; last_xfer_cyc = -1;
    prev_stall = 0; prev_hold_rs = 0;
    cur_last = l;
    first_reg = f[4:0];
    last_reg = l[4:0];
    start = 1;
    start_cyc = cyc;
    mon_en = 1;
    @(posedge clk); #1;
    start = 0;
    first_reg = 5'($urandom);
    last_reg = 5'($urandom);
  endtask

  task automatic drive(input int mode, input int k);
    case (mode)
      0: begin port_gnt = 1; out_ready = 1; end
      1: begin out_ready = (k % 2 == 0); port_gnt = !(k >= 3 && k <= 5); end
      default: begin
        port_gnt = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
      end
    endcase
  endtask

  task automatic run_dump(input int f, input int l, input int mode);
    int k;
    begin_dump(f, l);
    k = 0;
    while (n_done == 0 && k < 400) begin
      drive(mode, k);
      // A start during the dump must be ignored.
      start = (k == 4);
      @(posedge clk); #1;
      k++;
    end
    start = 0;
    port_gnt = 0;
    out_ready = 1;
    check("timeout", (n_done != 0) ? 1 : 0, 1);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 0;
    check("xfer_count", n_xfer, n_exp);
    check("done_count", n_done, 1);
    check("queue_left", exp_q.size(), 0);
    if (n_exp == 0) begin
      check("req_seen", saw_req, 0);
      check("valid_seen", saw_valid, 0);
    end else if (mode == 0) begin
      check("req_latency", first_req_cyc, start_cyc + 1);
      check("valid_latency", first_valid_cyc, start_cyc + 2);
      check("throughput", last_xfer_cyc - first_xfer_cyc, n_exp - 1);
    end
    $display("dump %0d..%0d mode %0d words %0d of %0d done %0d", f, l, mode, n_xfer, n_exp, n_done);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 0;

    regs[1] = 32'hc0ca_c01a;
    regs[2] = 32'hdede_2222;
    run_dump(1, 2, 0);
    run_dump(0, 4, 0);

    for (int i = 3; i < 32; i++) regs[i] = $urandom;
    run_dump(0, 31, 0);
    run_dump(5, 3, 0);
    run_dump(0, 31, 1);
    run_dump(3, 17, 1);

    // Reset in the middle of a dump, after three words have gone out.
    begin
      int k;
      begin_dump(0, 31);
      k = 0;
      while (n_xfer < 3 && k < 50) begin
        drive(0, k);
        @(posedge clk); #1;
        k++;
      end
      check("reset_prep", (n_xfer >= 3) ? 1 : 0, 1);
      reset = 1;
      mon_en = 0;
      @(posedge clk); #1;
      check_zero("midreset");
      reset = 0;
      for (int j = 0; j < 3; j++) begin
        @(posedge clk); #1;
        check("no_done_after_reset", done, 0);
      end
      $display("reset after %0d words", n_xfer);
    end
    run_dump(7, 12, 0);

    for (int n = 0; n < 12; n++) begin
      run_dump($urandom_range(0, 31), $urandom_range(0, 31), 2);
    end
    run_dump(31, 31, 0);
    run_dump(30, 31, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
